regfile_scoreboard: RTL and testbench

//  Parametrised 2-read/1-write register file with a per-register busy scoreboard.
//  It replaces the fixed 64-bit x 32 negedge-write register file in the datapath.
//  It adds synchronous clear, optional write-to-read bypass and busy tracking for
//  in-flight producers, so the pipeline can detect RAW hazards.
//  It sits between the decode stage (read ports, issue) and writeback (write port).

---
 rtl/regfile_scoreboard.sv | 61 ++++++
 tb/tb_regfile_scoreboard.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read/1-write register file with per-register busy scoreboard
module regfile_scoreboard #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  parameter int ZERO_REG = 31,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [AW-1:0]    RA,
  input  logic [AW-1:0]    RB,
  output logic [WIDTH-1:0] BusA,
  output logic [WIDTH-1:0] BusB,
  output logic             BusyA,
  output logic             BusyB,
  input  logic [AW-1:0]    RW,
  input  logic [WIDTH-1:0] BusW,
  input  logic             RegWr,
  input  logic             IssueVld,
  input  logic [AW-1:0]    IssueRd,
  output logic [AW:0]      BusyCnt
);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy, busy_nxt;
  logic wr_ok, iss_ok, hit_a, hit_b;

  // an address is live when it names a real register other than the zero register
  function automatic logic live(input logic [AW-1:0] a);
    return int'(a) < DEPTH && int'(a) != ZERO_REG;
  endfunction

  assign wr_ok = RegWr && live(RW);
  assign iss_ok = IssueVld && live(IssueRd);
  assign hit_a = BYPASS != 0 && wr_ok && RW == RA;
  assign hit_b = BYPASS != 0 && wr_ok && RW == RB;

  // set is applied after clear so a same-cycle reissue keeps the register busy
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) busy_nxt[RW] = 1'b0;
    if (iss_ok) busy_nxt[IssueRd] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
      BusyCnt <= '0;
    end else begin
      if (wr_ok) regs[RW] <= BusW;
      busy <= busy_nxt;
      BusyCnt <= (AW+1)'($countones(busy_nxt));
    end
  end

  assign BusA = !live(RA) ? '0 : hit_a ? BusW : regs[RA];
  assign BusB = !live(RB) ? '0 : hit_b ? BusW : regs[RB];
  assign BusyA = live(RA) && (hit_a ? iss_ok && IssueRd == RA : busy[RA]);
  assign BusyB = live(RB) && (hit_b ? iss_ok && IssueRd == RB : busy[RB]);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed table, corner sequences and random checks vs a reference model
module tb_regfile_scoreboard;
  logic Clk = 0, Reset = 1, RegWr = 0, IssueVld = 0, BusyA, BusyB;
  logic [4:0] RA = 0, RB = 0, RW = 0, IssueRd = 0;
  logic [63:0] BusA, BusB, BusW = 0;
  logic [5:0] BusyCnt;
  int checks = 0, failures = 0;

  logic [63:0] m_reg [32];
  bit m_busy [32];

  typedef struct {
    bit [4:0] ra, rb, rw, ird;
    bit [63:0] bw;
    bit wr, iv;
    bit [63:0] ea, eb;
    bit eba, ebb;
    int ecnt;
  } vec_t;
  vec_t tbl [13];

  regfile_scoreboard dut (
    .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .BusA(BusA), .BusB(BusB),
    .BusyA(BusyA), .BusyB(BusyB), .RW(RW), .BusW(BusW), .RegWr(RegWr),
    .IssueVld(IssueVld), .IssueRd(IssueRd), .BusyCnt(BusyCnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_bus(input bit [4:0] a);
    if (a == 31) return 0;
    if (RegWr && RW == a) return BusW;
    return m_reg[a];
  endfunction

  function automatic bit exp_busy(input bit [4:0] a);
    if (a == 31) return 0;
    if (RegWr && RW == a) return IssueVld && IssueRd == a;
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    foreach (m_busy[i]) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic drive(input bit rst, input bit [4:0] ra, rb, rw, input bit [63:0] bw,
                       input bit wr, iv, input bit [4:0] ird);
    Reset = rst; RA = ra; RB = rb; RW = rw; BusW = bw; RegWr = wr; IssueVld = iv; IssueRd = ird;
    @(negedge Clk);
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Reset) begin
      foreach (m_reg[i]) begin m_reg[i] = 0; m_busy[i] = 0; end
    end else begin
      if (RegWr && RW != 31) begin m_reg[RW] = BusW; m_busy[RW] = 0; end
      if (IssueVld && IssueRd != 31) m_busy[IssueRd] = 1;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " BusA"}, BusA, exp_bus(RA));
    check({tag, " BusB"}, BusB, exp_bus(RB));
    check({tag, " BusyA"}, 64'(BusyA), 64'(exp_busy(RA)));
    check({tag, " BusyB"}, 64'(BusyB), 64'(exp_busy(RB)));
    check({tag, " BusyCnt"}, 64'(BusyCnt), 64'(exp_cnt()));
  endtask

  initial begin
    //        ra  rb  rw  ird bw                        wr iv  ea                        eb                        eba ebb cnt
    tbl[0]  = '{0,  30, 0,  0,  0,                        0, 0,  0,                        0,                        0, 0, 0};
    tbl[1]  = '{31, 17, 0,  0,  0,                        0, 0,  0,                        0,                        0, 0, 0};
    tbl[2]  = '{5,  4,  5,  0,  64'hDEAD_BEEF_0123_4567,  1, 0,  64'hDEAD_BEEF_0123_4567,  0,                        0, 0, 0};
    tbl[3]  = '{5,  5,  0,  0,  0,                        0, 0,  64'hDEAD_BEEF_0123_4567,  64'hDEAD_BEEF_0123_4567,  0, 0, 0};
    tbl[4]  = '{31, 5,  31, 31, 64'hFFFF_FFFF_FFFF_FFFF,  1, 1,  0,                        64'hDEAD_BEEF_0123_4567,  0, 0, 0};
    tbl[5]  = '{31, 31, 0,  0,  0,                        0, 0,  0,                        0,                        0, 0, 0};
    tbl[6]  = '{3,  7,  0,  3,  0,                        0, 1,  0,                        0,                        0, 0, 0};
    tbl[7]  = '{3,  7,  0,  7,  0,                        0, 1,  0,                        0,                        1, 0, 1};
    tbl[8]  = '{3,  7,  0,  3,  0,                        0, 1,  0,                        0,                        1, 1, 2};
    tbl[9]  = '{3,  7,  7,  0,  64'h77,                   1, 0,  0,                        64'h77,                   1, 0, 2};
    tbl[10] = '{3,  7,  0,  0,  0,                        0, 0,  0,                        64'h77,                   1, 0, 1};
    tbl[11] = '{9,  3,  9,  9,  42,                       1, 1,  42,                       0,                        1, 1, 1};
    tbl[12] = '{9,  9,  0,  0,  0,                        0, 0,  42,                       42,                       1, 1, 2};

    foreach (m_reg[i]) begin m_reg[i] = 'x; m_busy[i] = 0; end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    for (int a = 0; a < 32; a++) begin
      drive(0, 5'(a), 5'(31 - a), 0, 0, 0, 0, 0);
      check("reset BusA", BusA, 0);
      check("reset BusB", BusB, 0);
      check("reset busy", 64'({BusyA, BusyB}), 0);
      check("reset BusyCnt", 64'(BusyCnt), 0);
      tick();
    end

    foreach (tbl[i]) begin
      drive(0, tbl[i].ra, tbl[i].rb, tbl[i].rw, tbl[i].bw, tbl[i].wr, tbl[i].iv, tbl[i].ird);
      check($sformatf("vec%0d BusA", i), BusA, tbl[i].ea);
      check($sformatf("vec%0d BusB", i), BusB, tbl[i].eb);
      check($sformatf("vec%0d BusyA", i), 64'(BusyA), 64'(tbl[i].eba));
      check($sformatf("vec%0d BusyB", i), 64'(BusyB), 64'(tbl[i].ebb));
      check($sformatf("vec%0d BusyCnt", i), 64'(BusyCnt), 64'(tbl[i].ecnt));
      tick();
    end

    // busy r1, r2, write r4, then reset colliding with a write and an issue
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 4, 7, 1, 1, 2);
    tick();
    drive(0, 4, 1, 0, 0, 0, 0, 0);
    check("pre-reset r4", BusA, 7);
    check("pre-reset busy r1", 64'(BusyB), 1);
    check("pre-reset BusyCnt", 64'(BusyCnt), 4);
    tick();
    drive(1, 4, 4, 4, 99, 1, 1, 5);
    tick();
    drive(0, 1, 2, 0, 0, 0, 0, 0);
    check("post-reset BusyCnt", 64'(BusyCnt), 0);
    check("post-reset busy r1", 64'(BusyA), 0);
    check("post-reset busy r2", 64'(BusyB), 0);
    tick();
    drive(0, 4, 5, 0, 0, 0, 0, 0);
    check("post-reset r4", BusA, 0);
    check("post-reset busy r5", 64'(BusyB), 0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      bit [4:0] ra = 5'($urandom_range(0, 31)), rb = 5'($urandom_range(0, 31));
      bit [4:0] rw = $urandom_range(0, 3) == 0 ? ra : 5'($urandom_range(0, 31));
      bit [4:0] ird = $urandom_range(0, 3) == 0 ? rw : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 99) == 0, ra, rb, rw, {$urandom, $urandom},
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, ird);
      check_model("rand");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
